// File: rtl/mem_ctrl_pkg.sv
// Shared FSM states, wait-counter width and the request address check.
// The check flags byte addresses beyond the array or not aligned to a data word.
package mem_ctrl_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ISSUE,
      RESP
   } state_e;

   function automatic logic addr_err(input logic [31:0] addr, input int depth, input int nbytes);
      logic [63:0] limit;
      logic [31:0] low_mask;
      limit    = 64'(depth) * 64'(nbytes);
      low_mask = 32'(nbytes - 1);
      return ({32'd0, addr} >= limit) || ((addr & low_mask) != 32'd0);
   endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter; done is high while enabled with one cycle left.
// Latency: load/decrement take effect on the next edge; no backpressure.
module wait_counter
   import mem_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   input  logic             en,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (en && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding request bridge to a synchronous-read memory port.
// Response WAIT_STATES+2 cycles after accept; req_ready only while idle.
module data_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 16384,
   parameter int WAIT_STATES = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [31:0]              req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   input  logic [DATA_WIDTH/8-1:0]  req_wmask,
   output logic                     resp_valid,
   output logic [DATA_WIDTH-1:0]    resp_rdata,
   output logic                     resp_err,
   output logic [$clog2(DEPTH)-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [DATA_WIDTH/8-1:0]  mem_wmask,
   output logic                     mem_we,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   localparam int NB  = DATA_WIDTH / 8;
   localparam int OFS = $clog2(NB);
   localparam int AW  = $clog2(DEPTH);

   state_e          state_q, state_d;
   logic            we_q, we_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0]   wmask_q, wmask_d;
   logic            err_q, err_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [NB-1:0]   mem_wmask_q, mem_wmask_d;
   logic            resp_valid_q, resp_valid_d;
   logic            resp_err_q, resp_err_d;
   logic            rd_ok_q, rd_ok_d;
   logic            go_issue;
   logic            cnt_load, cnt_en, cnt_done;

   wait_counter u_wait_counter (
      .clk   (clk),
      .rst   (rst),
      .load  (cnt_load),
      .value (CNT_W'(WAIT_STATES)),
      .en    (cnt_en),
      .done  (cnt_done)
   );

   assign cnt_en = (state_q == WAIT);

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      err_d        = err_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      rd_ok_d      = 1'b0;
      cnt_load     = 1'b0;
      go_issue     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               waddr_d = req_addr[OFS +: AW];
               wdata_d = req_wdata;
               wmask_d = req_wmask;
               err_d   = addr_err(req_addr, DEPTH, NB);
               if (WAIT_STATES > 0) begin
                  state_d  = WAIT;
                  cnt_load = 1'b1;
               end else begin
                  state_d  = ISSUE;
                  go_issue = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_done) begin
               state_d  = ISSUE;
               go_issue = 1'b1;
            end
         end
         ISSUE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = err_q;
            rd_ok_d      = !we_q && !err_q;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The _d fields already hold the request when issuing straight from IDLE.
      if (go_issue) begin
         mem_addr_d  = waddr_d;
         mem_wdata_d = wdata_d;
         mem_wmask_d = wmask_d;
         mem_we_d    = we_d && (wmask_d != '0) && !err_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         err_q        <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rd_ok_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         err_q        <= err_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         rd_ok_q      <= rd_ok_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   // Memory data arrives during RESP, so the read path is gated rather than re-registered.
   assign resp_rdata = rd_ok_q ? mem_rdata : '0;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (0, 2 and 3 wait states) each on a behavioural memory,
// checked against a transaction-level reference model of memory contents, errors and timing.
module tb_data_mem_ctrl;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst;
   logic mem_init;

   logic        req_valid [NI];
   logic        req_ready [NI];
   logic        req_we    [NI];
   logic [31:0] req_addr  [NI];
   logic [31:0] req_wdata [NI];
   logic [3:0]  req_wmask [NI];
   logic        resp_valid[NI];
   logic [31:0] resp_rdata[NI];
   logic        resp_err  [NI];
   logic [13:0] mem_addr  [NI];
   logic [31:0] mem_wdata [NI];
   logic [3:0]  mem_wmask [NI];
   logic        mem_we    [NI];

   logic [31:0] ref_mem [NI][256];

   typedef struct {
      logic        err;
      logic [31:0] rd;
   } exp_t;

   exp_t bq[$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g
      logic [7:0]  mem_b [4][256];
      logic [31:0] rdata_q;

      data_mem_ctrl #(
         .DATA_WIDTH  (32),
         .DEPTH       (16384),
         .WAIT_STATES (gi == 0 ? 0 : (gi == 1 ? 2 : 3))
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[gi]),
         .req_ready  (req_ready[gi]),
         .req_we     (req_we[gi]),
         .req_addr   (req_addr[gi]),
         .req_wdata  (req_wdata[gi]),
         .req_wmask  (req_wmask[gi]),
         .resp_valid (resp_valid[gi]),
         .resp_rdata (resp_rdata[gi]),
         .resp_err   (resp_err[gi]),
         .mem_addr   (mem_addr[gi]),
         .mem_wdata  (mem_wdata[gi]),
         .mem_wmask  (mem_wmask[gi]),
         .mem_we     (mem_we[gi]),
         .mem_rdata  (rdata_q)
      );

      // Synchronous-read memory; only the low 256 words are backed.
      always @(posedge clk) begin
         if (mem_init) begin
            for (int a = 0; a < 256; a++)
               for (int b = 0; b < 4; b++)
                  mem_b[b][a] <= 8'h00;
            rdata_q <= '0;
         end else begin
            rdata_q <= {mem_b[3][mem_addr[gi][7:0]], mem_b[2][mem_addr[gi][7:0]],
                        mem_b[1][mem_addr[gi][7:0]], mem_b[0][mem_addr[gi][7:0]]};
            if (mem_we[gi])
               for (int b = 0; b < 4; b++)
                  if (mem_wmask[gi][b])
                     mem_b[b][mem_addr[gi][7:0]] <= mem_wdata[gi][8*b +: 8];
         end
      end
   end

   function automatic int ws_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
   endfunction

   task automatic chk(input int i, input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL i%0d %s observed=%0h expected=%0h", i, tag, obs, exp);
      end
   endtask

   // Transaction-level reference: error rule, byte-merge writes, word reads.
   task automatic model(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, output logic err, output logic [31:0] rd, output logic wr);
      logic [7:0] idx;
      idx = addr[9:2];
      err = (addr >= 32'h0001_0000) || (addr % 4 != 0);
      wr  = we && !err && (mask != 4'd0);
      rd  = (!we && !err) ? ref_mem[i][idx] : 32'd0;
      if (wr)
         for (int b = 0; b < 4; b++)
            if (mask[b]) ref_mem[i][idx][8*b +: 8] = wdata[8*b +: 8];
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 32'h0001_0000 + 32'($urandom_range(0, 4095) << 2);
      if (r == 1) return 32'(($urandom_range(0, 31) << 2) | $urandom_range(1, 3));
      return 32'($urandom_range(0, 31) << 2);
   endfunction

   // Call at a negedge; returns at the negedge where the controller is idle again.
   task automatic do_txn(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, output logic [31:0] obs_rd, output logic obs_err);
      logic        e_err, e_wr;
      logic [31:0] e_rd;
      int          w, n;
      w = ws_of(i);
      obs_rd  = '0;
      obs_err = 1'b0;
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i]  = addr;
      req_wdata[i] = wdata;
      req_wmask[i] = mask;
      n = 0;
      while (req_ready[i] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(i, "accept_ready", 32'(req_ready[i]), 32'd1);
      model(i, we, addr, wdata, mask, e_err, e_rd, e_wr);
      for (int k = 1; k <= w + 3; k++) begin
         @(negedge clk);
         chk(i, "req_ready", 32'(req_ready[i]), 32'(k == w + 3));
         chk(i, "mem_we", 32'(mem_we[i]), 32'((k == w + 1) && e_wr));
         if (k == w + 1 && e_wr) begin
            chk(i, "mem_addr", 32'(mem_addr[i]), 32'(addr[15:2]));
            chk(i, "mem_wdata", mem_wdata[i], wdata);
            chk(i, "mem_wmask", 32'(mem_wmask[i]), 32'(mask));
         end
         chk(i, "resp_valid", 32'(resp_valid[i]), 32'(k == w + 2));
         if (k == w + 2) begin
            chk(i, "resp_err", 32'(resp_err[i]), 32'(e_err));
            chk(i, "resp_rdata", resp_rdata[i], e_rd);
            obs_rd  = resp_rdata[i];
            obs_err = resp_err[i];
         end else begin
            chk(i, "idle_err", 32'(resp_err[i]), 32'd0);
            chk(i, "idle_rdata", resp_rdata[i], 32'd0);
         end
         // Busy-time request garbage must be ignored and must not disturb the latched one.
         if (k == 1) begin
            req_valid[i] = 1'b1;
            req_we[i]    = 1'($urandom);
            req_addr[i]  = $urandom;
            req_wdata[i] = $urandom;
            req_wmask[i] = 4'($urandom);
         end
         if (k == w + 2) req_valid[i] = 1'b0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er, e_err, e_wr;
      logic [31:0] e_rd;
      exp_t        e;
      int          nacc, cyc, last;
      bit          acc_now;

      rst      = 1'b0;
      mem_init = 1'b1;
      for (int i = 0; i < NI; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         req_wmask[i] = '0;
         for (int a = 0; a < 256; a++) ref_mem[i][a] = '0;
      end
      repeat (3) @(negedge clk);

      for (int i = 0; i < NI; i++) begin
         chk(i, "rst_req_ready", 32'(req_ready[i]), 32'd1);
         chk(i, "rst_resp_valid", 32'(resp_valid[i]), 32'd0);
         chk(i, "rst_resp_err", 32'(resp_err[i]), 32'd0);
         chk(i, "rst_resp_rdata", resp_rdata[i], 32'd0);
         chk(i, "rst_mem_we", 32'(mem_we[i]), 32'd0);
         chk(i, "rst_mem_addr", 32'(mem_addr[i]), 32'd0);
         chk(i, "rst_mem_wdata", mem_wdata[i], 32'd0);
         chk(i, "rst_mem_wmask", 32'(mem_wmask[i]), 32'd0);
      end
      mem_init = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk(i, "release_ready", 32'(req_ready[i]), 32'd1);

      // Zero wait states: read-back of a stored word.
      do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
      chk(0, "read_deadbeef", rd, 32'hDEADBEEF);
      chk(0, "read_deadbeef_err", 32'(er), 32'd0);

      // Three wait states: partial-mask write merges into the existing word.
      do_txn(2, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, rd, er);
      do_txn(2, 1'b1, 32'h20, 32'h11223344, 4'b0011, rd, er);
      do_txn(2, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
      chk(2, "masked_merge", rd, 32'hAABB3344);

      // Out of range read and misaligned write.
      do_txn(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, rd, er);
      chk(0, "oor_err", 32'(er), 32'd1);
      chk(0, "oor_rdata", rd, 32'd0);
      do_txn(2, 1'b1, 32'h22, 32'hFFFF_FFFF, 4'hF, rd, er);
      chk(2, "misalign_err", 32'(er), 32'd1);
      do_txn(2, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
      chk(2, "misalign_unchanged", rd, 32'hAABB3344);

      // Zero-mask write completes without touching memory.
      do_txn(0, 1'b1, 32'h10, 32'h0, 4'h0, rd, er);
      chk(0, "mask0_err", 32'(er), 32'd0);
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
      chk(0, "mask0_unchanged", rd, 32'hDEADBEEF);

      // Last legal word.
      do_txn(0, 1'b1, 32'hFFFC, 32'h0BADF00D, 4'hF, rd, er);
      do_txn(0, 1'b0, 32'hFFFC, 32'h0, 4'h0, rd, er);
      chk(0, "last_word_err", 32'(er), 32'd0);
      chk(0, "last_word_rd", rd, 32'h0BADF00D);

      // Back-to-back with req_valid held high on the two-wait-state instance.
      nacc = 0; cyc = 0; last = -1;
      req_valid[1] = 1'b1;
      req_we[1]    = 1'($urandom);
      req_addr[1]  = 32'($urandom_range(0, 3) << 2);
      req_wdata[1] = $urandom;
      req_wmask[1] = 4'($urandom);
      while ((nacc < 6 || bq.size() != 0) && cyc < 100) begin
         if (resp_valid[1] === 1'b1) begin
            if (bq.size() == 0) begin
               chk(1, "burst_extra_resp", 32'(resp_valid[1]), 32'd0);
            end else begin
               e = bq.pop_front();
               chk(1, "burst_rdata", resp_rdata[1], e.rd);
               chk(1, "burst_err", 32'(resp_err[1]), 32'(e.err));
            end
         end
         acc_now = 1'b0;
         if (req_ready[1] === 1'b1 && req_valid[1] && nacc < 6) begin
            if (last >= 0) chk(1, "burst_ready_gap", 32'(cyc - last), 32'd5);
            last = cyc;
            model(1, req_we[1], req_addr[1], req_wdata[1], req_wmask[1], e_err, e_rd, e_wr);
            e.err = e_err;
            e.rd  = e_rd;
            bq.push_back(e);
            nacc++;
            acc_now = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (acc_now) begin
            if (nacc < 6) begin
               req_we[1]    = 1'($urandom);
               req_addr[1]  = 32'($urandom_range(0, 3) << 2);
               req_wdata[1] = $urandom;
               req_wmask[1] = 4'($urandom);
            end else begin
               req_valid[1] = 1'b0;
            end
         end
      end
      chk(1, "burst_done", 32'((nacc == 6) && (bq.size() == 0)), 32'd1);

      // Reset during the wait phase of a write drops it entirely.
      do_txn(2, 1'b1, 32'h40, 32'h13579BDF, 4'hF, rd, er);
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b1;
      req_addr[2]  = 32'h40;
      req_wdata[2] = 32'hCAFEF00D;
      req_wmask[2] = 4'hF;
      @(negedge clk);
      req_valid[2] = 1'b0;
      @(negedge clk);
      chk(2, "pre_rst_in_wait", 32'(req_ready[2]), 32'd0);
      rst = 1'b0;
      #1;
      chk(2, "rst_async_ready", 32'(req_ready[2]), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk(2, "rst_no_mem_we", 32'(mem_we[2]), 32'd0);
         chk(2, "rst_no_resp", 32'(resp_valid[2]), 32'd0);
      end
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk(2, "post_rst_ready", 32'(req_ready[2]), 32'd1);
         chk(2, "post_rst_no_mem_we", 32'(mem_we[2]), 32'd0);
         chk(2, "post_rst_no_resp", 32'(resp_valid[2]), 32'd0);
      end
      do_txn(2, 1'b0, 32'h40, 32'h0, 4'h0, rd, er);
      chk(2, "rst_write_dropped", rd, 32'h13579BDF);

      // Randomized traffic across all instances.
      for (int t = 0; t < 60; t++) begin
         do_txn(int'($urandom_range(0, NI - 1)), 1'($urandom), rand_addr(), $urandom,
                4'($urandom_range(0, 15)), rd, er);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
